// File: rtl/csi_2_pkg.sv
// CSI-2 packet-layer constants, receive-controller state encoding and the
// 6-bit header ECC shared by the single-lane controller and the future lane merger.
package csi_2_pkg;

  localparam logic [5:0] DT_FS        = 6'h00;
  localparam logic [5:0] DT_FE        = 6'h01;
  localparam logic [5:0] DT_LS        = 6'h02;
  localparam logic [5:0] DT_LE        = 6'h03;
  localparam logic [5:0] DT_SHORT_MAX = 6'h0F;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_WAIT_STOP,
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD,
    ST_CRC,
    ST_DRAIN
  } rxState_t;

  // d = {WC MSB, WC LSB, DI}; each mask selects the data bits covered by one parity bit
  function automatic logic [5:0] csi2_ecc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = ^(d & 24'hF12CB7);
    p[1] = ^(d & 24'hF2555B);
    p[2] = ^(d & 24'h749A6D);
    p[3] = ^(d & 24'hB8E38E);
    p[4] = ^(d & 24'hDF03F0);
    p[5] = ^(d & 24'hEFFC00);
    return p;
  endfunction

endpackage

// File: rtl/csi_2_rx_packet_ctrl_if.sv
// Lane-side and packet-side signal bundle of the CSI-2 receive packet controller.
interface csi_2_rx_packet_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             Enable;
  logic             Shutdown;
  logic [7:0]       RxDataHS;
  logic             RxValidHS;
  logic             RxActiveHS;
  logic             RxSyncHS;
  logic             Stopstate;
  logic             ErrSotHS;
  logic             ErrSotSyncHS;
  logic [7:0]       PktData;
  logic             PktValid;
  logic             PktStart;
  logic             PktEnd;
  logic [5:0]       DataType;
  logic [1:0]       VirtChan;
  logic [15:0]      WordCount;
  logic             FrameStart;
  logic             FrameEnd;
  logic             ErrHeader;
  logic             ErrTrunc;
  logic             ErrSot;
  logic [CNT_W-1:0] PktCount;
  logic [CNT_W-1:0] ErrCount;

  modport master (
    input  Enable, RxDataHS, RxValidHS, RxActiveHS, RxSyncHS, Stopstate,
           ErrSotHS, ErrSotSyncHS,
    output Shutdown, PktData, PktValid, PktStart, PktEnd, DataType, VirtChan,
           WordCount, FrameStart, FrameEnd, ErrHeader, ErrTrunc, ErrSot,
           PktCount, ErrCount
  );

  modport slave (
    output Enable, RxDataHS, RxValidHS, RxActiveHS, RxSyncHS, Stopstate,
           ErrSotHS, ErrSotSyncHS,
    input  Shutdown, PktData, PktValid, PktStart, PktEnd, DataType, VirtChan,
           WordCount, FrameStart, FrameEnd, ErrHeader, ErrTrunc, ErrSot,
           PktCount, ErrCount
  );
endinterface

// File: rtl/csi_2_ecc_check.sv
// Combinational CSI-2 packet-header check: ECC byte must match the Hamming
// code over DI and WC, with the two spare ECC bits at zero.
module csi_2_ecc_check
  import csi_2_pkg::*;
(
  input  logic [7:0]  di,
  input  logic [15:0] wc,
  input  logic [7:0]  ecc,
  output logic        ok
);

  assign ok = (ecc[7:6] == 2'b00) && (ecc[5:0] == csi2_ecc({wc, di}));

endmodule

// File: rtl/csi_2_rx_packet_ctrl.sv
// Sequences one CSI-2 data lane and frames each HS burst into header, payload
// and checksum phases, reporting packet markers, errors and saturating counts.
module csi_2_rx_packet_ctrl
  import csi_2_pkg::*;
#(
  parameter int MAX_WC = 4096,
  parameter int CNT_W  = 16
) (
  input logic                    RxByteClkHS,
  input logic                    ResetN,
  csi_2_rx_packet_ctrl_if.master bus
);

  localparam logic [15:0] MaxWc = 16'(MAX_WC);

  rxState_t    state, stateNxt;
  logic [1:0]  hdrIdx, hdrIdxNxt;
  logic [15:0] remain, remainNxt;
  logic        crcIdx, crcIdxNxt;
  logic [7:0]  diReg, wcLsbReg, wcMsbReg;
  logic [15:0] hdrWc;
  logic        eccOk, wcOk, isShort, sotErr, inFlight;
  logic        startNxt, endNxt, fsNxt, feNxt, errHdrNxt, truncNxt, sotNxt;
  logic        goodNxt, hdrLoad, emitNxt, errAny;

  assign hdrWc    = {wcMsbReg, wcLsbReg};
  assign isShort  = diReg[5:0] <= DT_SHORT_MAX;
  assign wcOk     = isShort || (hdrWc <= MaxWc);
  assign sotErr   = bus.ErrSotHS | bus.ErrSotSyncHS;
  assign inFlight = (state == ST_HDR) || (state == ST_PAYLOAD) || (state == ST_CRC);
  assign errAny   = errHdrNxt | truncNxt | sotNxt;
  assign bus.Shutdown = (state == ST_OFF);

  // The ECC byte is checked as it arrives, against the three captured header bytes
  csi_2_ecc_check uEccCheck (
    .di  (diReg),
    .wc  (hdrWc),
    .ecc (bus.RxDataHS),
    .ok  (eccOk)
  );

  always_comb begin
    stateNxt  = state;
    hdrIdxNxt = hdrIdx;
    remainNxt = remain;
    crcIdxNxt = crcIdx;
    startNxt  = 1'b0;
    endNxt    = 1'b0;
    fsNxt     = 1'b0;
    feNxt     = 1'b0;
    errHdrNxt = 1'b0;
    truncNxt  = 1'b0;
    sotNxt    = 1'b0;
    goodNxt   = 1'b0;
    hdrLoad   = 1'b0;
    emitNxt   = 1'b0;
    if (!bus.Enable) begin
      stateNxt = ST_OFF;
      endNxt   = inFlight;
      truncNxt = inFlight;
    end else begin
      case (state)
        ST_OFF:       stateNxt = ST_WAIT_STOP;
        ST_WAIT_STOP: if (bus.Stopstate) stateNxt = ST_IDLE;
        ST_IDLE: begin
          if (sotErr) begin
            sotNxt   = 1'b1;
            stateNxt = ST_DRAIN;
          end else if (bus.RxValidHS && bus.RxSyncHS) begin
            hdrIdxNxt = 2'd1;
            stateNxt  = ST_HDR;
          end
        end
        ST_HDR: begin
          if (!bus.RxActiveHS) begin
            endNxt   = 1'b1;
            truncNxt = 1'b1;
            stateNxt = ST_IDLE;
          end else if (sotErr) begin
            sotNxt   = 1'b1;
            stateNxt = ST_DRAIN;
          end else if (bus.RxValidHS) begin
            if (hdrIdx != 2'd3) begin
              hdrIdxNxt = hdrIdx + 2'd1;
            end else if (eccOk && wcOk) begin
              startNxt = 1'b1;
              hdrLoad  = 1'b1;
              if (isShort) begin
                endNxt   = 1'b1;
                goodNxt  = 1'b1;
                fsNxt    = (diReg[5:0] == DT_FS);
                feNxt    = (diReg[5:0] == DT_FE);
                stateNxt = ST_DRAIN;
              end else begin
                remainNxt = hdrWc;
                crcIdxNxt = 1'b0;
                stateNxt  = (hdrWc == 16'd0) ? ST_CRC : ST_PAYLOAD;
              end
            end else begin
              errHdrNxt = 1'b1;
              stateNxt  = ST_DRAIN;
            end
          end
        end
        ST_PAYLOAD: begin
          if (!bus.RxActiveHS) begin
            endNxt   = 1'b1;
            truncNxt = 1'b1;
            stateNxt = ST_IDLE;
          end else if (bus.RxValidHS) begin
            emitNxt   = 1'b1;
            remainNxt = remain - 16'd1;
            if (remain == 16'd1) stateNxt = ST_CRC;
          end
        end
        ST_CRC: begin
          if (!bus.RxActiveHS) begin
            endNxt   = 1'b1;
            truncNxt = 1'b1;
            stateNxt = ST_IDLE;
          end else if (bus.RxValidHS) begin
            if (crcIdx) begin
              endNxt   = 1'b1;
              goodNxt  = 1'b1;
              stateNxt = ST_DRAIN;
            end else begin
              crcIdxNxt = 1'b1;
            end
          end
        end
        ST_DRAIN: if (!bus.RxActiveHS) stateNxt = ST_IDLE;
        default:  stateNxt = ST_OFF;
      endcase
    end
  end

  // Stage p1: control state, marker pulses, held header fields and counters
  always_ff @(posedge RxByteClkHS or negedge ResetN) begin
    if (!ResetN) begin
      state          <= ST_OFF;
      hdrIdx         <= 2'd0;
      remain         <= 16'd0;
      crcIdx         <= 1'b0;
      bus.PktValid   <= 1'b0;
      bus.PktStart   <= 1'b0;
      bus.PktEnd     <= 1'b0;
      bus.FrameStart <= 1'b0;
      bus.FrameEnd   <= 1'b0;
      bus.ErrHeader  <= 1'b0;
      bus.ErrTrunc   <= 1'b0;
      bus.ErrSot     <= 1'b0;
      bus.DataType   <= 6'd0;
      bus.VirtChan   <= 2'd0;
      bus.WordCount  <= 16'd0;
      bus.PktCount   <= '0;
      bus.ErrCount   <= '0;
    end else begin
      state          <= stateNxt;
      hdrIdx         <= hdrIdxNxt;
      remain         <= remainNxt;
      crcIdx         <= crcIdxNxt;
      bus.PktValid   <= emitNxt;
      bus.PktStart   <= startNxt;
      bus.PktEnd     <= endNxt;
      bus.FrameStart <= fsNxt;
      bus.FrameEnd   <= feNxt;
      bus.ErrHeader  <= errHdrNxt;
      bus.ErrTrunc   <= truncNxt;
      bus.ErrSot     <= sotNxt;
      if (hdrLoad) begin
        bus.DataType  <= diReg[5:0];
        bus.VirtChan  <= diReg[7:6];
        bus.WordCount <= hdrWc;
      end
      if (goodNxt && !(&bus.PktCount)) bus.PktCount <= bus.PktCount + 1'b1;
      if (errAny && !(&bus.ErrCount))  bus.ErrCount <= bus.ErrCount + 1'b1;
    end
  end

  // Stage p1 datapath: payload byte and header capture carry no reset
  always_ff @(posedge RxByteClkHS) begin
    if (emitNxt) bus.PktData <= bus.RxDataHS;
    if (state == ST_IDLE && bus.RxValidHS && bus.RxSyncHS) diReg <= bus.RxDataHS;
    if (state == ST_HDR && bus.RxValidHS) begin
      if (hdrIdx == 2'd1) wcLsbReg <= bus.RxDataHS;
      if (hdrIdx == 2'd2) wcMsbReg <= bus.RxDataHS;
    end
  end

endmodule

// File: tb/tb_csi_2_rx_packet_ctrl.sv
// Bench for the CSI-2 receive packet controller: bursts are described at packet
// level, expected markers/bytes are queued with their cycle, a monitor pops them.
module tb_csi_2_rx_packet_ctrl;

  localparam int MAX_WC = 4096;
  localparam logic [6:0] P_START = 7'b1000000;
  localparam logic [6:0] P_END   = 7'b0100000;
  localparam logic [6:0] P_FS    = 7'b0010000;
  localparam logic [6:0] P_FE    = 7'b0001000;
  localparam logic [6:0] P_HDR   = 7'b0000100;
  localparam logic [6:0] P_TRUNC = 7'b0000010;
  localparam logic [6:0] P_SOT   = 7'b0000001;

  typedef struct {
    int          c;
    logic [6:0]  p;
    logic [5:0]  dt;
    logic [1:0]  vc;
    logic [15:0] wc;
    int          pc;
    int          ec;
  } ev_t;

  typedef struct {
    int         c;
    logic [7:0] d;
  } dat_t;

  logic clk  = 1'b0;
  logic rstN = 1'b0;
  int   cyc  = 0;
  int   nChecks = 0;
  int   nFail   = 0;

  ev_t  evq[$];
  dat_t dq[$];

  logic [5:0]  mDt = 6'd0;
  logic [1:0]  mVc = 2'd0;
  logic [15:0] mWc = 16'd0;
  int          mPkt = 0;
  int          mErr = 0;

  csi_2_rx_packet_ctrl_if #(.CNT_W(16)) bus ();

  csi_2_rx_packet_ctrl #(.MAX_WC(MAX_WC), .CNT_W(16)) dut (
    .RxByteClkHS (clk),
    .ResetN      (rstN),
    .bus         (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    nChecks++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // CSI-2 header ECC from the published parity equations (-1 pads short rows)
  function automatic logic [7:0] refEcc(input logic [7:0] di, input logic [15:0] wc);
    int tbl [6][14];
    logic [23:0] d;
    logic [7:0]  e;
    tbl = '{'{0,1,2,4,5,7,10,11,13,16,20,21,22,23},
            '{0,1,3,4,6,8,10,12,14,17,20,21,22,23},
            '{0,2,3,5,6,9,11,12,15,18,20,21,22,-1},
            '{1,2,3,7,8,9,13,14,15,19,20,21,23,-1},
            '{4,5,6,7,8,9,16,17,18,19,20,22,23,-1},
            '{10,11,12,13,14,15,16,17,18,19,21,22,23,-1}};
    d = {wc, di};
    e = 8'h00;
    for (int p = 0; p < 6; p++)
      for (int k = 0; k < 14; k++)
        if (tbl[p][k] >= 0) e[p] = e[p] ^ d[tbl[p][k]];
    return e;
  endfunction

  task automatic pushEv(input int c, input logic [6:0] p);
    ev_t e;
    if ((p & (P_HDR | P_TRUNC | P_SOT)) != 7'd0 && mErr < 65535) mErr++;
    if ((p & P_END) != 7'd0 && (p & P_TRUNC) == 7'd0 && mPkt < 65535) mPkt++;
    e = '{c, p, mDt, mVc, mWc, mPkt, mErr};
    evq.push_back(e);
  endtask

  // One HS burst: header, payload/CRC for good long packets, junk tail; cut after ncut bytes
  task automatic burst(input logic [7:0] di, input logic [15:0] wc, input logic [7:0] ecc,
                       input logic [7:0] pBase, input int extra, input int ncut,
                       input bit dropEn, input bit gaps);
    logic [7:0] b[$];
    bit ok, isShort;
    int need, n, c;
    isShort = (di[5:0] < 6'h10);
    ok = (ecc == refEcc(di, wc)) && (isShort || int'(wc) <= MAX_WC);
    b.push_back(di); b.push_back(wc[7:0]); b.push_back(wc[15:8]); b.push_back(ecc);
    if (!isShort && ok) begin
      for (int k = 0; k < int'(wc); k++) b.push_back((pBase != 0) ? 8'(int'(pBase) + k) : 8'($urandom));
      b.push_back(8'($urandom)); b.push_back(8'($urandom));
    end
    for (int k = 0; k < extra; k++) b.push_back(8'($urandom));
    n = (ncut < 0 || ncut > b.size()) ? b.size() : ncut;
    need = (ok && !isShort) ? int'(wc) + 6 : 4;
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0)
        while ($urandom_range(3) == 0) begin
          @(negedge clk); bus.RxValidHS = 1'b0; bus.RxSyncHS = 1'b0; bus.RxDataHS = 8'($urandom);
        end
      @(negedge clk);
      bus.RxActiveHS = 1'b1; bus.RxValidHS = 1'b1; bus.RxSyncHS = (i == 0); bus.RxDataHS = b[i];
      c = cyc + 1;
      if (i == 3) begin
        if (!ok) pushEv(c, P_HDR);
        else begin
          mDt = di[5:0]; mVc = di[7:6]; mWc = wc;
          if (isShort) pushEv(c, P_START | P_END | ((di[5:0] == 6'h00) ? P_FS : 7'd0)
                                 | ((di[5:0] == 6'h01) ? P_FE : 7'd0));
          else pushEv(c, P_START);
        end
      end
      if (ok && !isShort && i >= 4 && i < 4 + int'(wc)) dq.push_back('{c, b[i]});
      if (ok && !isShort && i == need - 1) pushEv(c, P_END);
    end
    @(negedge clk);
    bus.RxValidHS = 1'b0; bus.RxSyncHS = 1'b0;
    c = cyc + 1;
    if (dropEn) bus.Enable = 1'b0;
    else bus.RxActiveHS = 1'b0;
    if (n > 0 && n < need) pushEv(c, P_END | P_TRUNC);
    @(negedge clk); bus.RxActiveHS = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // SoT error raised after nHdr header bytes (0 = while idle)
  task automatic sotBurst(input int nHdr, input bit syncErr);
    for (int i = 0; i < nHdr; i++) begin
      @(negedge clk);
      bus.RxActiveHS = 1'b1; bus.RxValidHS = 1'b1; bus.RxSyncHS = (i == 0); bus.RxDataHS = 8'($urandom);
    end
    @(negedge clk);
    bus.RxActiveHS = 1'b1; bus.RxValidHS = 1'b0; bus.RxSyncHS = 1'b0;
    if (syncErr) bus.ErrSotSyncHS = 1'b1; else bus.ErrSotHS = 1'b1;
    pushEv(cyc + 1, P_SOT);
    @(negedge clk);
    bus.ErrSotHS = 1'b0; bus.ErrSotSyncHS = 1'b0; bus.RxValidHS = 1'b1; bus.RxDataHS = 8'($urandom);
    @(negedge clk); bus.RxValidHS = 1'b0; bus.RxActiveHS = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Monitor: every marker cycle and every payload beat must match the queued expectation
  initial begin
    logic [6:0] pul;
    ev_t e;
    dat_t d;
    forever begin
      @(posedge clk); #1;
      if (bus.PktValid) begin
        if (dq.size() == 0) begin
          nChecks++; nFail++;
          $display("FAIL unexpected_beat: got data 0x%0h at cycle %0d, expected none", bus.PktData, cyc);
        end else begin
          d = dq.pop_front();
          chk("payload_data", bus.PktData, d.d);
          chk("payload_cycle", cyc, d.c);
        end
      end
      pul = {bus.PktStart, bus.PktEnd, bus.FrameStart, bus.FrameEnd,
             bus.ErrHeader, bus.ErrTrunc, bus.ErrSot};
      if (pul != 7'd0) begin
        if (evq.size() == 0) begin
          nChecks++; nFail++;
          $display("FAIL unexpected_marker: got pulses 0x%0h at cycle %0d, expected none", pul, cyc);
        end else begin
          e = evq.pop_front();
          chk("marker_pulses", pul, e.p);
          chk("marker_cycle", cyc, e.c);
          chk("DataType", bus.DataType, e.dt);
          chk("VirtChan", bus.VirtChan, e.vc);
          chk("WordCount", bus.WordCount, e.wc);
          chk("PktCount", bus.PktCount, e.pc);
          chk("ErrCount", bus.ErrCount, e.ec);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected completion within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  rdi, recc;
    logic [15:0] rwc;
    int          rcut;
    bus.Enable = 1'b0; bus.RxDataHS = 8'h00; bus.RxValidHS = 1'b0; bus.RxActiveHS = 1'b0;
    bus.RxSyncHS = 1'b0; bus.Stopstate = 1'b0; bus.ErrSotHS = 1'b0; bus.ErrSotSyncHS = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_Shutdown", bus.Shutdown, 1);
    chk("rst_PktValid", bus.PktValid, 0);
    chk("rst_PktEnd", bus.PktEnd, 0);
    chk("rst_DataType", bus.DataType, 0);
    chk("rst_WordCount", bus.WordCount, 0);
    chk("rst_PktCount", bus.PktCount, 0);
    chk("rst_ErrCount", bus.ErrCount, 0);
    rstN = 1'b1;
    @(negedge clk); bus.Enable = 1'b1;
    chk("shutdown_before_edge", bus.Shutdown, 1);
    @(posedge clk); #1;
    chk("shutdown_after_enable", bus.Shutdown, 0);
    // Without Stopstate the lane is not yet usable: this burst must be ignored
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.RxActiveHS = 1'b1; bus.RxValidHS = 1'b1; bus.RxSyncHS = (i == 0);
      bus.RxDataHS = (i == 1) ? 8'h05 : ((i == 3) ? refEcc(8'h00, 16'h0005) : 8'h00);
    end
    @(negedge clk); bus.RxValidHS = 1'b0; bus.RxActiveHS = 1'b0; bus.Stopstate = 1'b1;
    repeat (3) @(negedge clk);

    burst(8'h00, 16'h0005, refEcc(8'h00, 16'h0005), 8'h00, 2, -1, 1'b0, 1'b0);
    burst(8'h2A, 16'h0004, refEcc(8'h2A, 16'h0004), 8'hA1, 0, -1, 1'b0, 1'b1);
    burst(8'h00, 16'h0000, 8'h01, 8'h00, 3, -1, 1'b0, 1'b0);
    burst(8'h6B, 16'h0008, refEcc(8'h6B, 16'h0008), 8'h30, 0, 7, 1'b0, 1'b0);
    burst(8'h41, 16'h1234, refEcc(8'h41, 16'h1234), 8'h00, 1, -1, 1'b0, 1'b0);
    burst(8'h2A, 16'h1001, refEcc(8'h2A, 16'h1001), 8'h00, 2, -1, 1'b0, 1'b0);
    burst(8'h2C, 16'h0000, refEcc(8'h2C, 16'h0000), 8'h00, 1, -1, 1'b0, 1'b1);
    burst(8'h24, 16'h0006, refEcc(8'h24, 16'h0006), 8'h10, 0, 6, 1'b1, 1'b0);
    chk("shutdown_after_disable", bus.Shutdown, 1);
    @(negedge clk); bus.Enable = 1'b1;
    repeat (3) @(negedge clk);
    sotBurst(0, 1'b0);
    sotBurst(2, 1'b1);
    burst(8'hC2, 16'h0003, refEcc(8'hC2, 16'h0003), 8'h00, 0, 2, 1'b0, 1'b0);

    for (int t = 0; t < 60; t++) begin
      rdi = 8'($urandom);
      if ($urandom_range(2) == 0) rdi[5:4] = 2'b00;
      rwc = (rdi[5:4] == 2'b00) ? 16'($urandom) : 16'($urandom_range(0, 24));
      recc = refEcc(rdi, rwc);
      if ($urandom_range(6) == 0) recc = recc ^ 8'(1 << $urandom_range(7));
      rcut = ($urandom_range(4) == 0) ? int'($urandom_range(1, 10)) : -1;
      burst(rdi, rwc, recc, 8'h00, int'($urandom_range(0, 2)), rcut, 1'b0, 1'b1);
    end

    repeat (5) @(negedge clk);
    chk("markers_outstanding", evq.size(), 0);
    chk("beats_outstanding", dq.size(), 0);
    chk("final_PktCount", bus.PktCount, mPkt);
    chk("final_ErrCount", bus.ErrCount, mErr);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
